hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit_pkg.sv | 16 +
 rtl/hazard_control_unit_hazard_detect.sv | 51 +++++
 rtl/hazard_control_unit.sv | 126 ++++++++++++
 tb/tb_hazard_control_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit slice.
//   state_t       : control FSM state (RUN, DRAIN, HALTED), 2-bit encoding
//   ECALL_OPCODE  : major opcode of the SYSTEM/ecall instruction
//   X17_IDX       : register index of a7 (x17), which carries the ecall code
package hazard_control_unit_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [6:0] ECALL_OPCODE = 7'b1110011;
   localparam logic [4:0] X17_IDX      = 5'd17;

endpackage

// File: rtl/hazard_control_unit_hazard_detect.sv
// Combinational hazard comparisons for the instruction sitting in ID.
// Ports:
//   ifIdInst_i       : instruction in ID
//   idExRd_i         : destination of the instruction in EX
//   idExMemRead_i    : EX instruction is a load
//   idExRegWrite_i   : EX instruction writes the register file
//   exMemRd_i        : destination of the instruction in MEM
//   exMemMemRead_i   : MEM instruction is a load
//   loadUseHazard_o  : ID reads a register a load in EX has not produced yet
//   ecallHazard_o    : ecall in ID cannot see a final x17 value yet
//   isEcall_o        : instruction in ID is an ecall
module hazard_detect
   import hazard_control_unit_pkg::*;
(
   input  logic [31:0] ifIdInst_i,
   input  logic [4:0]  idExRd_i,
   input  logic        idExMemRead_i,
   input  logic        idExRegWrite_i,
   input  logic [4:0]  exMemRd_i,
   input  logic        exMemMemRead_i,
   output logic        loadUseHazard_o,
   output logic        ecallHazard_o,
   output logic        isEcall_o
);

   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [6:0] opcode;
   logic       unusedInstBits;

   assign rs1    = ifIdInst_i[19:15];
   assign rs2    = ifIdInst_i[24:20];
   assign opcode = ifIdInst_i[6:0];

   // funct/rd fields play no part in hazard detection
   assign unusedInstBits = ^{ifIdInst_i[31:25], ifIdInst_i[14:7]};

   // rs1/rs2 are compared whatever the format; a stall on an unused field
   // only costs a cycle, never correctness. x0 is never a real dependency.
   assign loadUseHazard_o = idExMemRead_i && (idExRd_i != 5'd0) &&
                            ((idExRd_i == rs1) || (idExRd_i == rs2));

   assign isEcall_o = (opcode == ECALL_OPCODE);

   // x17 is forwarded into ID from EX/MEM and WB, but a value still being
   // computed in EX or still being loaded in MEM is not available yet
   assign ecallHazard_o = isEcall_o &&
                          ((idExRegWrite_i && (idExRd_i == X17_IDX)) ||
                           (exMemMemRead_i && (exMemRd_i == X17_IDX)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: stalls on load-use and ecall hazards, drains the
// pipeline after a halting ecall and then holds the core halted until reset.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   IF_ID_inst          : instruction in ID
//   ID_EX_rd/_mem_read/_reg_write : EX stage destination and control
//   EX_MEM_rd/_mem_read : MEM stage destination and load flag
//   ecall_x17           : forwarded x17 value seen by ID
//   pc_write, IF_ID_write, ID_EX_bubble : stall controls
//   is_halted           : core halted
//   stall_count         : saturating count of hazard stall cycles
module hazard_control_unit
   import hazard_control_unit_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int HALT_CODE    = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IF_ID_inst,
   input  logic [4:0]  ID_EX_rd,
   input  logic        ID_EX_mem_read,
   input  logic        ID_EX_reg_write,
   input  logic [4:0]  EX_MEM_rd,
   input  logic        EX_MEM_mem_read,
   input  logic [31:0] ecall_x17,
   output logic        pc_write,
   output logic        IF_ID_write,
   output logic        ID_EX_bubble,
   output logic        is_halted,
   output logic [31:0] stall_count
);

   localparam int CW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

   state_t        state_q;
   logic [CW-1:0] drainCnt_q;
   logic [31:0]   stallCount_q;
   logic [31:0]   stallCount_d;

   logic loadUseHazard;
   logic ecallHazard;
   logic isEcall;
   logic stallNow;
   logic haltingEcall;

   hazard_detect uDetect (
      .ifIdInst_i      (IF_ID_inst),
      .idExRd_i        (ID_EX_rd),
      .idExMemRead_i   (ID_EX_mem_read),
      .idExRegWrite_i  (ID_EX_reg_write),
      .exMemRd_i       (EX_MEM_rd),
      .exMemMemRead_i  (EX_MEM_mem_read),
      .loadUseHazard_o (loadUseHazard),
      .ecallHazard_o   (ecallHazard),
      .isEcall_o       (isEcall)
   );

   // Hazards only matter while running; a stall always beats a halt so an
   // ecall waiting on x17 never starts the drain with a stale value
   assign stallNow     = (state_q == RUN) && (loadUseHazard || ecallHazard);
   assign haltingEcall = (state_q == RUN) && isEcall && !stallNow &&
                         (ecall_x17 == 32'(HALT_CODE));

   // Stall controls: freeze fetch and inject a bubble on a hazard or any
   // time the core is draining or halted; reset forces a free-running view
   always_comb begin
      pc_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_bubble = 1'b0;
      is_halted    = 1'b0;
      if (!reset) begin
         if (stallNow || (state_q != RUN)) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
         end
         is_halted = (state_q == HALTED);
      end
   end

   // Stall counter sticks at all-ones instead of wrapping
   always_comb begin
      stallCount_d = stallCount_q;
      if (stallNow && (stallCount_q != 32'hFFFF_FFFF)) begin
         stallCount_d = stallCount_q + 32'd1;
      end
   end

   assign stall_count = stallCount_q;

   // Control FSM: RUN until a halting ecall, then DRAIN_CYCLES drain cycles
   // (counter runs DRAIN_CYCLES-1 down to 0), then HALTED until reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RUN;
         drainCnt_q   <= '0;
         stallCount_q <= '0;
      end else begin
         stallCount_q <= stallCount_d;
         unique case (state_q)
            RUN: begin
               if (haltingEcall) begin
                  state_q    <= DRAIN;
                  drainCnt_q <= DRAIN_LOAD;
               end
            end
            DRAIN: begin
               if (drainCnt_q == '0) begin
                  state_q <= HALTED;
               end else begin
                  drainCnt_q <= drainCnt_q - CW'(1);
               end
            end
            HALTED: begin
               state_q <= HALTED;
            end
            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a
// cycle-level behavioural model.
module tb_hazard_control_unit;

   localparam int DRAIN = 3;
   localparam int HALTV = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IF_ID_inst;
   logic [4:0]  ID_EX_rd;
   logic        ID_EX_mem_read;
   logic        ID_EX_reg_write;
   logic [4:0]  EX_MEM_rd;
   logic        EX_MEM_mem_read;
   logic [31:0] ecall_x17;
   logic        pc_write;
   logic        IF_ID_write;
   logic        ID_EX_bubble;
   logic        is_halted;
   logic [31:0] stall_count;

   int testsRun    = 0;
   int testsFailed = 0;

   // Behavioural model state
   bit          mDraining;
   bit          mHalted;
   int          mDrainLeft;
   logic [31:0] mStalls;

   typedef struct {
      logic [31:0] inst;
      logic [4:0]  idExRd;
      logic        idExMemRead;
      logic        idExRegWrite;
      logic [4:0]  exMemRd;
      logic        exMemMemRead;
      logic        expStall;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   hazard_control_unit #(.DRAIN_CYCLES(DRAIN), .HALT_CODE(HALTV)) dut (
      .clk             (clk),
      .reset           (reset),
      .IF_ID_inst      (IF_ID_inst),
      .ID_EX_rd        (ID_EX_rd),
      .ID_EX_mem_read  (ID_EX_mem_read),
      .ID_EX_reg_write (ID_EX_reg_write),
      .EX_MEM_rd       (EX_MEM_rd),
      .EX_MEM_mem_read (EX_MEM_mem_read),
      .ecall_x17       (ecall_x17),
      .pc_write        (pc_write),
      .IF_ID_write     (IF_ID_write),
      .ID_EX_bubble    (ID_EX_bubble),
      .is_halted       (is_halted),
      .stall_count     (stall_count)
   );

   function automatic logic [31:0] mkInst(logic [6:0] opc, logic [4:0] rs1, logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b0, 5'd1, opc};
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(logic [31:0] inst, logic [4:0] rd, logic mr, logic rw,
                                logic [4:0] exRd, logic exMr, logic [31:0] x17);
      IF_ID_inst      = inst;
      ID_EX_rd        = rd;
      ID_EX_mem_read  = mr;
      ID_EX_reg_write = rw;
      EX_MEM_rd       = exRd;
      EX_MEM_mem_read = exMr;
      ecall_x17       = x17;
   endtask

   task automatic applyIdle();
      applyStimulus(32'h0000_0013, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic modelReset();
      mDraining  = 1'b0;
      mHalted    = 1'b0;
      mDrainLeft = 0;
      mStalls    = 32'd0;
   endtask

   // Called at a negedge: holds reset for one full cycle
   task automatic resetDut();
      reset = 1'b1;
      applyIdle();
      modelReset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic checkStallOuts(string name, logic stall);
      checkOutput({name, ".pc_write"},     {31'd0, pc_write},     {31'd0, !stall});
      checkOutput({name, ".IF_ID_write"},  {31'd0, IF_ID_write},  {31'd0, !stall});
      checkOutput({name, ".ID_EX_bubble"}, {31'd0, ID_EX_bubble}, {31'd0, stall});
   endtask

   // Counts cycles until is_halted rises (bounded), checking drain controls
   task automatic measureDrain(string name);
      int seen;
      seen = 0;
      #1;
      while (!is_halted && seen < 10) begin
         checkStallOuts({name, ".drain"}, 1'b1);
         seen++;
         nextCycle();
         #1;
      end
      checkOutput({name, ".drainCycles"}, seen, DRAIN);
      checkOutput({name, ".is_halted"}, {31'd0, is_halted}, 32'd1);
      @(negedge clk);
   endtask

   // One random cycle: compare against the model, clock it, advance the model
   task automatic modelCheckAndStep();
      bit lu, eh, isEc, stall, busy;
      #1;
      lu   = ID_EX_mem_read && ID_EX_rd != 0 &&
             (ID_EX_rd == IF_ID_inst[19:15] || ID_EX_rd == IF_ID_inst[24:20]);
      isEc = (IF_ID_inst[6:0] == 7'h73);
      eh   = isEc && ((ID_EX_reg_write && ID_EX_rd == 17) ||
                      (EX_MEM_mem_read && EX_MEM_rd == 17));
      busy  = mDraining || mHalted;
      stall = !busy && (lu || eh);
      checkStallOuts("rand", stall || busy);
      checkOutput("rand.is_halted", {31'd0, is_halted}, {31'd0, mHalted});
      checkOutput("rand.stall_count", stall_count, mStalls);
      @(posedge clk);
      if (mHalted) begin
      end else if (mDraining) begin
         mDrainLeft--;
         if (mDrainLeft == 0) begin
            mDraining = 1'b0;
            mHalted   = 1'b1;
         end
      end else if (stall) begin
         if (mStalls != 32'hFFFF_FFFF) mStalls++;
      end else if (isEc && ecall_x17 == HALTV) begin
         mDraining  = 1'b1;
         mDrainLeft = DRAIN;
      end
      @(negedge clk);
   endtask

   initial begin
      int expStalls;
      logic [31:0] inst;

      vecs[0] = '{mkInst(7'h33, 5'd5, 5'd7),  5'd5,  1, 0, 5'd0,  0, 1};
      vecs[1] = '{mkInst(7'h33, 5'd3, 5'd5),  5'd5,  1, 1, 5'd0,  0, 1};
      vecs[2] = '{mkInst(7'h33, 5'd0, 5'd7),  5'd0,  1, 1, 5'd0,  0, 0};
      vecs[3] = '{mkInst(7'h33, 5'd5, 5'd7),  5'd5,  0, 1, 5'd0,  0, 0};
      vecs[4] = '{mkInst(7'h73, 5'd0, 5'd0),  5'd17, 0, 1, 5'd0,  0, 1};
      vecs[5] = '{mkInst(7'h73, 5'd0, 5'd0),  5'd0,  0, 0, 5'd17, 1, 1};
      vecs[6] = '{mkInst(7'h73, 5'd0, 5'd0),  5'd17, 0, 0, 5'd17, 0, 0};
      vecs[7] = '{mkInst(7'h33, 5'd1, 5'd2),  5'd17, 0, 1, 5'd17, 1, 0};
      vecs[8] = '{mkInst(7'h73, 5'd0, 5'd0),  5'd16, 0, 1, 5'd16, 1, 0};
      vecs[9] = '{mkInst(7'h03, 5'd4, 5'd5),  5'd3,  1, 1, 5'd0,  0, 0};

      // Reset state, with a load-use hazard present on the inputs
      reset = 1'b1;
      applyStimulus(mkInst(7'h33, 5'd5, 5'd7), 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0);
      #1;
      checkStallOuts("reset", 1'b0);
      checkOutput("reset.is_halted", {31'd0, is_halted}, 32'd0);
      checkOutput("reset.stall_count", stall_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      applyIdle();
      @(negedge clk);

      // Directed vector table, all in RUN with a non-halting x17
      expStalls = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].inst, vecs[i].idExRd, vecs[i].idExMemRead,
                       vecs[i].idExRegWrite, vecs[i].exMemRd, vecs[i].exMemMemRead, 32'd0);
         #1;
         checkStallOuts($sformatf("vec%0d", i), vecs[i].expStall);
         if (vecs[i].expStall) expStalls++;
         nextCycle();
      end
      checkOutput("vec.stall_count", stall_count, expStalls);

      // lw x5 then add x6,x5,x7: exactly one stall cycle
      resetDut();
      applyStimulus(mkInst(7'h33, 5'd5, 5'd7), 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0);
      #1 checkStallOuts("loadUse", 1'b1);
      nextCycle();
      applyStimulus(mkInst(7'h33, 5'd5, 5'd7), 5'd6, 1'b0, 1'b0, 5'd5, 1'b1, 32'd0);
      #1 checkStallOuts("loadUse.after", 1'b0);
      checkOutput("loadUse.stall_count", stall_count, 32'd1);
      @(negedge clk);

      // rd=0, rs1=0: no stall
      resetDut();
      applyStimulus(mkInst(7'h33, 5'd0, 5'd7), 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0);
      #1 checkStallOuts("rdZero", 1'b0);
      nextCycle();
      checkOutput("rdZero.stall_count", stall_count, 32'd0);

      // Ecall hazard stall, then halting ecall, drain, halt
      resetDut();
      applyStimulus(mkInst(7'h73, 5'd0, 5'd0), 5'd17, 1'b0, 1'b1, 5'd0, 1'b0, 32'd10);
      #1 checkStallOuts("ecallHaz", 1'b1);
      nextCycle();
      applyStimulus(mkInst(7'h73, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd10);
      #1 checkStallOuts("ecallGo", 1'b0);
      checkOutput("ecallGo.is_halted", {31'd0, is_halted}, 32'd0);
      nextCycle();
      applyIdle();
      measureDrain("halt");
      applyStimulus(mkInst(7'h33, 5'd5, 5'd7), 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0);
      #1 checkStallOuts("halted", 1'b1);
      nextCycle();
      checkOutput("halted.is_halted", {31'd0, is_halted}, 32'd1);
      checkOutput("halted.stall_count", stall_count, 32'd1);

      // Non-halting ecall is a NOP
      resetDut();
      applyStimulus(mkInst(7'h73, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd5);
      #1 checkStallOuts("ecallNop", 1'b0);
      nextCycle();
      applyIdle();
      for (int i = 0; i < 5; i++) begin
         #1 checkStallOuts("ecallNop.run", 1'b0);
         checkOutput("ecallNop.is_halted", {31'd0, is_halted}, 32'd0);
         nextCycle();
      end

      // Reset in the middle of the drain
      resetDut();
      applyStimulus(mkInst(7'h33, 5'd5, 5'd7), 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0);
      nextCycle();
      applyStimulus(mkInst(7'h73, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd10);
      nextCycle();
      applyIdle();
      nextCycle();
      #1 checkStallOuts("midDrain", 1'b1);
      checkOutput("midDrain.stall_count", stall_count, 32'd1);
      #1 reset = 1'b1;
      #1 checkStallOuts("midDrainReset", 1'b0);
      checkOutput("midDrainReset.is_halted", {31'd0, is_halted}, 32'd0);
      checkOutput("midDrainReset.stall_count", stall_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      nextCycle();
      #1 checkStallOuts("afterReset", 1'b0);
      @(negedge clk);
      applyStimulus(mkInst(7'h73, 5'd0, 5'd0), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd10);
      nextCycle();
      applyIdle();
      measureDrain("rehalt");

      // Saturation of the stall counter
      resetDut();
      force dut.stallCount_q = 32'hFFFF_FFFE;
      #1 release dut.stallCount_q;
      #1 checkOutput("sat.preload", stall_count, 32'hFFFF_FFFE);
      @(negedge clk);
      applyStimulus(mkInst(7'h33, 5'd5, 5'd7), 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         #1 checkOutput($sformatf("sat.stall%0d", i), stall_count, 32'hFFFF_FFFF);
         @(negedge clk);
      end

      // Randomized traffic against the behavioural model
      resetDut();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 59) == 0) resetDut();
         inst = $urandom;
         if ($urandom_range(0, 2) == 0) begin
            inst[6:0]   = 7'h73;
            inst[24:15] = 10'd0;
         end else begin
            inst[19:15] = 5'($urandom_range(0, 7));
            inst[24:20] = 5'($urandom_range(0, 7));
         end
         applyStimulus(inst,
                       ($urandom_range(0, 3) == 0) ? 5'd17 : 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 5'd17 : 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 32'd10 : 32'($urandom_range(0, 20)));
         modelCheckAndStep();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
